// File: rtl/starship_pkg.sv
// Shared constants for the starship game logic: direction indices, FSM encoding,
// LFSR taps, and small helpers for spawn selection and kill counting.
package starship_pkg;

  localparam logic [1:0] DIR_TOP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT  = 2'd1;
  localparam logic [1:0] DIR_BOTTOM = 2'd2;
  localparam logic [1:0] DIR_LEFT   = 2'd3;

  // Bit 0 is PLAY and bit 1 is OVER, so each status output is a single register bit.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  // Polynomial x^16+x^14+x^13+x^11+1 in the right-shifting form (feedback enters bit 15).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [9:0] SCORE_MAX = 10'd1023;

  // Returns {found, dir}: the first unoccupied direction at cand, cand+1, cand+2, cand+3 (mod 4).
  function automatic logic [2:0] pick_free_dir(input logic [3:0] occ, input logic [1:0] cand);
    logic [2:0] res;
    logic [1:0] d;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      d = cand + 2'(i);
      if (!occ[d]) res = {1'b1, d};
    end
    return res;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the spawn-direction source; loads seed on reset.
module lfsr16
  import starship_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= seed;
    end else if (enable) begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/monster_controller.sv
// Game-side monster driver: spawns tunnel monsters, detects kills and breaches, keeps score/state.
// Optional feature macro MONSTER_SPEEDUP_EN shortens the spawn interval on every 8th kill.
module monster_controller
  import starship_pkg::*;
#(
  parameter int          SPAWN_TICKS     = 200,
  parameter int          ATTACK_TICKS    = 600,
  parameter int          MIN_SPAWN_TICKS = 40,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [3:0] monster_vga,
  output logic [3:0] monster_ctrl,
  output logic [3:0] broken,
  output logic [9:0] score,
  output logic       playing,
  output logic       game_over
);

  // Protocol: monster_ctrl[d] is our request; the display echoes it on monster_vga[d] one cycle
  // later. A direction arms once both are high; a later drop of monster_vga[d] while armed is a kill.

  localparam int          FLOOR_TICKS = (MIN_SPAWN_TICKS > SPAWN_TICKS) ? SPAWN_TICKS : MIN_SPAWN_TICKS;
  localparam logic [15:0] SPAWN_IV    = 16'((SPAWN_TICKS > FLOOR_TICKS) ? SPAWN_TICKS : FLOOR_TICKS);
  localparam logic [15:0] ATTACK_IV   = 16'(ATTACK_TICKS);

  logic [1:0]  r_state;
  logic [3:0]  r_ctrl;
  logic [3:0]  r_armed;
  logic [3:0]  r_broken;
  logic [9:0]  r_score;
  logic [15:0] r_spawn_cnt;
  logic [15:0] r_atk [4];

  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;
  logic [15:0] w_interval;
  logic        w_play;
  logic [2:0]  w_pick;
  logic [3:0]  w_spawn_vec;
  logic [3:0]  w_kill;
  logic [3:0]  w_breach;
  logic [3:0]  w_ctrl_next;
  logic [3:0]  w_armed_next;
  logic        w_fatal;
  logic [2:0]  w_nkill;
  logic [10:0] w_score_sum;
  logic [9:0]  w_score_next;

  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .enable  (1'b1),
    .seed    (LFSR_SEED),
    .q       (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:2];
  assign w_play        = (r_state == ST_PLAY);
  assign w_pick        = pick_free_dir(r_ctrl, w_lfsr[1:0]);

  always_comb begin
    w_spawn_vec = '0;
    if (w_play && r_spawn_cnt == '0 && w_pick[2]) begin
      case (w_pick[1:0])
        DIR_TOP:    w_spawn_vec = 4'b0001;
        DIR_RIGHT:  w_spawn_vec = 4'b0010;
        DIR_BOTTOM: w_spawn_vec = 4'b0100;
        DIR_LEFT:   w_spawn_vec = 4'b1000;
        default:    w_spawn_vec = '0;
      endcase
    end
    w_kill   = '0;
    w_breach = '0;
    for (int d = 0; d < 4; d++) begin
      w_kill[d]   = r_ctrl[d] & r_armed[d] & ~monster_vga[d];
      // A kill on the same cycle as timer expiry takes precedence over the breach.
      w_breach[d] = r_ctrl[d] & (r_atk[d] == '0) & ~w_kill[d];
    end
    w_ctrl_next  = (r_ctrl & ~w_kill & ~w_breach) | w_spawn_vec;
    w_armed_next = (r_armed | (r_ctrl & monster_vga)) & ~w_kill & ~w_breach & ~w_spawn_vec;
    w_fatal      = |(w_breach & r_broken);
    w_nkill      = popcount4(w_kill);
    w_score_sum  = {1'b0, r_score} + {8'b0, w_nkill};
    w_score_next = (w_score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_score_sum[9:0];
  end

`ifdef MONSTER_SPEEDUP_EN
  localparam logic [15:0] FLOOR_IV = 16'(FLOOR_TICKS);

  logic [15:0] r_interval;
  logic [2:0]  r_kill_mod;
  logic [3:0]  w_kmod_sum;
  logic [15:0] w_shrunk;

  assign w_kmod_sum = {1'b0, r_kill_mod} + {1'b0, w_nkill};
  assign w_shrunk   = r_interval - (r_interval >> 3);

  // Kills are counted mod 8; a carry out of the counter marks an 8th kill.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_interval <= SPAWN_IV;
      r_kill_mod <= '0;
    end else if (!w_play) begin
      if (Start) begin
        r_interval <= SPAWN_IV;
        r_kill_mod <= '0;
      end
    end else begin
      r_kill_mod <= w_kmod_sum[2:0];
      if (w_kmod_sum[3]) r_interval <= (w_shrunk < FLOOR_IV) ? FLOOR_IV : w_shrunk;
    end
  end

  assign w_interval = r_interval;
`else
  assign w_interval = SPAWN_IV;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_armed     <= '0;
      r_broken    <= '0;
      r_score     <= '0;
      r_spawn_cnt <= SPAWN_IV;
      for (int d = 0; d < 4; d++) r_atk[d] <= '0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          r_spawn_cnt <= (r_spawn_cnt == '0) ? w_interval : r_spawn_cnt - 16'd1;
          for (int d = 0; d < 4; d++) begin
            if (w_spawn_vec[d]) r_atk[d] <= ATTACK_IV;
            else if (r_ctrl[d] && r_atk[d] != '0) r_atk[d] <= r_atk[d] - 16'd1;
          end
          r_ctrl   <= w_fatal ? 4'b0000 : w_ctrl_next;
          r_armed  <= w_armed_next;
          r_broken <= r_broken | w_breach;
          r_score  <= w_score_next;
          if (w_fatal) r_state <= ST_OVER;
        end
        default: begin
          if (Start) begin
            r_state     <= ST_PLAY;
            r_ctrl      <= '0;
            r_armed     <= '0;
            r_broken    <= '0;
            r_score     <= '0;
            r_spawn_cnt <= SPAWN_IV;
            for (int d = 0; d < 4; d++) r_atk[d] <= '0;
          end
        end
      endcase
    end
  end

  assign monster_ctrl = r_ctrl;
  assign broken       = r_broken;
  assign score        = r_score;
  assign playing      = r_state[0];
  assign game_over    = r_state[1];

endmodule

// File: doc/monster_controller.md
# monster_controller

Game-side driver for the monster interface of the VGA starship display. It spawns tunnel monsters, raises the per-direction monster request toward the display controller, and detects kills when the display drops its mirrored flag. It runs an attack timer per live monster and latches shield breaks, keeping score and game state. It sits beside the display controller on the same slow game clock.

## Interface
- `SPAWN_TICKS`, default 200: ticks between spawn attempts.
- `ATTACK_TICKS`, default 600: ticks a monster lives before it breaches.
- `MIN_SPAWN_TICKS`, default 40: floor for the spawn interval under speed-up.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `Clk` input 1: slow game clock, the same clock as the display controller.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Start` input 1: level; begins or restarts a game.
- `monster_vga` input 4: display's mirrored monster flags. Index 0 top, 1 right, 2 bottom, 3 left.
- `monster_ctrl` output 4: monster present requests, same indexing.
- `broken` output 4: sticky shield-broken flags.
- `score` output 10: kill count.
- `playing` output 1: high in PLAY.
- `game_over` output 1: high in OVER.

## Operation
- FSM states are IDLE, PLAY and OVER.
  - Reset enters IDLE.
  - IDLE→PLAY when `Start`=1.
  - OVER→PLAY when `Start`=1.
  - PLAY→OVER on the second breach of any one direction.
- Entering PLAY clears `monster_ctrl`, `broken`, `score` and all timers, and loads the spawn counter with the current interval. `Start` is ignored while in PLAY.
- Spawn counter: decrements once per cycle in PLAY. At 0 it reloads and attempts a spawn.
- Spawn direction:
  - The candidate direction is `lfsr[1:0]`.
  - If the candidate is occupied, probe (d+1) mod 4, then (d+2) mod 4, then (d+3) mod 4, and take the first free direction.
  - If all four directions are occupied, skip the spawn.
  - On spawn, set `monster_ctrl[d]`, clear `armed[d]`, and load `atk[d]`=ATTACK_TICKS.
- Occupancy for the spawn decision is the registered `monster_ctrl` value from the start of the cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state.
- Arming: `armed[d]` sets once `monster_ctrl[d]` and `monster_vga[d]` are both 1. This covers the display's one-cycle mirror delay.
- Kill: when `monster_ctrl[d]`, `armed[d]` and `!monster_vga[d]` are all true, clear `monster_ctrl[d]` and `armed[d]`, and increment `score`. `score` saturates at 1023. Multiple kills in one cycle add their count.
- Breach: when `atk[d]` reaches 0 with `monster_ctrl[d]` still 1 and no kill:
  - clear `monster_ctrl[d]`;
  - if `broken[d]`=0, set it;
  - otherwise go to OVER.
- Simultaneous events:
  - Kill and breach on the same d in the same cycle: the kill wins.
  - Kill and a spawn choosing that d in the same cycle: the spawn treats d as occupied and moves on to the next free direction.
- OVER: `monster_ctrl` is forced to 0. `score` and `broken` hold. Timers freeze.
- Reset mid-game: all state returns to reset values immediately.

## Timing
- Reset values: `monster_ctrl`=0, `broken`=0, `score`=0, `playing`=0, `game_over`=0. Spawn counter=SPAWN_TICKS, LFSR=LFSR_SEED.
- All outputs are registered.
- `monster_ctrl[d]` rises in the cycle after the spawn counter reads 0.
- A kill is visible on `monster_ctrl` and `score` one cycle after the `monster_vga[d]` falling edge is sampled.
- The first spawn attempt occurs SPAWN_TICKS+1 cycles after PLAY entry.
- Breach occurs ATTACK_TICKS+1 cycles after spawn.
- `game_over` rises in the cycle after the fatal breach.

## Configuration
- `MONSTER_SPEEDUP_EN` defined:
  - every 8th kill reduces the spawn interval by interval>>3, floored at MIN_SPAWN_TICKS;
  - the new interval applies at the next reload;
  - entering PLAY restores SPAWN_TICKS.
- `MONSTER_SPEEDUP_EN` undefined: the interval is fixed at SPAWN_TICKS, and MIN_SPAWN_TICKS is unused.

## Structure
- Package `starship_pkg` holds:
  - direction indices DIR_TOP=0, DIR_RIGHT=1, DIR_BOTTOM=2, DIR_LEFT=3;
  - the FSM state encoding;
  - the LFSR tap constant.
- Sub-module `lfsr16`: ports Clk, Reset_n, enable, seed and q. It is instantiated once.

## Test plan
- Spawn timing: Reset_n low then high, `Start`=1 with SPAWN_TICKS=4 and seed fixed → exactly one `monster_ctrl` bit rises at cycle 5 after PLAY entry, at the index given by `lfsr[1:0]`.
- Kill: mirror `monster_ctrl` into `monster_vga` with a one-cycle delay, then drop `monster_vga[0]` while `monster_ctrl[0]`=1 → next cycle `monster_ctrl[0]`=0 and `score`=1.
- Unarmed drop ignored: drop `monster_vga[d]` before it has ever risen → no kill and no score change.
- Breach and game over: ATTACK_TICKS=10, no kills on top → `broken[0]`=1 after the first breach; the second top breach gives `game_over`=1 and `monster_ctrl`=0.
- Simultaneous kill and breach on d=2 → `score` increments and `broken[2]` stays 0.
- Occupancy: all four directions occupied → the spawn is skipped and the counter reloads. With `MONSTER_SPEEDUP_EN`, 8 kills at SPAWN_TICKS=200 → next interval 175.
